stall_reg_d: RTL and testbench

- D->E pipeline register fused with the pipeline's hazard detector.
- Samples D-stage fields into E every cycle.
- Compares D-stage source registers and their TUse values against the TNew of instructions in E and M; on a data hazard it asserts Stall to freeze F/D and injects a bubble into E.
- Tracks the multi-cycle mult/div unit with a busy counter and stalls dependent D-stage instructions while it is busy.

---
 rtl/stall_reg_d.sv | 127 ++++++++++++
 tb/tb_stall_reg_d.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_reg_d.sv
// D->E pipeline register with integrated data/mult-div hazard detection and bubble injection.
// Optional stall statistics counter enabled by defining STALL_CNT_EN.
module stall_reg_d #(
  parameter logic [7:0]  NOP_TYPE = 8'd0,
  parameter int unsigned MD_LAT   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Pc_D,
  input  logic [31:0] RD1_D,
  input  logic [31:0] RD2_D,
  input  logic [4:0]  Addr1_D,
  input  logic [4:0]  Addr2_D,
  input  logic [4:0]  WR_D,
  input  logic        RegWrite_D,
  input  logic        MemWrite_D,
  input  logic [1:0]  MemToReg_D,
  input  logic [7:0]  InstrType_D,
  input  logic [7:0]  TNew_D,
  input  logic [7:0]  TUse1_D,
  input  logic [7:0]  TUse2_D,
  input  logic        MdStart_D,
  input  logic        MdUse_D,
  input  logic [4:0]  WR_M,
  input  logic        RegWrite_M,
  input  logic [7:0]  TNew_M,
  output logic [31:0] Pc_E,
  output logic [31:0] RD1_E,
  output logic [31:0] RD2_E,
  output logic [4:0]  Addr1_E,
  output logic [4:0]  Addr2_E,
  output logic [4:0]  WR_E,
  output logic        RegWrite_E,
  output logic        MemWrite_E,
  output logic        MdStart_E,
  output logic [1:0]  MemToReg_E,
  output logic [7:0]  InstrType_E,
  output logic [7:0]  TNew_E,
`ifdef STALL_CNT_EN
  output logic [31:0] StallCnt,
`endif
  output logic        Stall,
  output logic        MdBusy
);

  localparam logic [3:0] MdLatCnt = 4'(MD_LAT);

  logic [3:0] md_cnt;
  logic       hz_e1, hz_e2, hz_m1, hz_m2, hz_md;

  assign MdBusy = (md_cnt != 4'd0);

  always_comb begin
    hz_e1 = (Addr1_D != 5'd0) && RegWrite_E && (WR_E == Addr1_D) && (TNew_E > TUse1_D);
    hz_e2 = (Addr2_D != 5'd0) && RegWrite_E && (WR_E == Addr2_D) && (TNew_E > TUse2_D);
    hz_m1 = (Addr1_D != 5'd0) && RegWrite_M && (WR_M == Addr1_D) && (TNew_M > TUse1_D);
    hz_m2 = (Addr2_D != 5'd0) && RegWrite_M && (WR_M == Addr2_D) && (TNew_M > TUse2_D);
    // A start still sitting in E has not loaded the counter yet, so it counts as busy too.
    hz_md = (MdUse_D || MdStart_D) && (MdBusy || MdStart_E);
    Stall = hz_e1 | hz_e2 | hz_m1 | hz_m2 | hz_md;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      Pc_E        <= 32'h0000_3000;
      RD1_E       <= 32'd0;
      RD2_E       <= 32'd0;
      Addr1_E     <= 5'd0;
      Addr2_E     <= 5'd0;
      WR_E        <= 5'd0;
      RegWrite_E  <= 1'b0;
      MemWrite_E  <= 1'b0;
      MdStart_E   <= 1'b0;
      MemToReg_E  <= 2'd0;
      InstrType_E <= NOP_TYPE;
      TNew_E      <= 8'd0;
    end else if (Stall) begin
      // Bubble: PC is kept only so traces show which instruction is waiting.
      Pc_E        <= Pc_D;
      RD1_E       <= 32'd0;
      RD2_E       <= 32'd0;
      Addr1_E     <= 5'd0;
      Addr2_E     <= 5'd0;
      WR_E        <= 5'd0;
      RegWrite_E  <= 1'b0;
      MemWrite_E  <= 1'b0;
      MdStart_E   <= 1'b0;
      MemToReg_E  <= 2'd0;
      InstrType_E <= NOP_TYPE;
      TNew_E      <= 8'd0;
    end else begin
      Pc_E        <= Pc_D;
      RD1_E       <= RD1_D;
      RD2_E       <= RD2_D;
      Addr1_E     <= Addr1_D;
      Addr2_E     <= Addr2_D;
      WR_E        <= WR_D;
      RegWrite_E  <= RegWrite_D;
      MemWrite_E  <= MemWrite_D;
      MdStart_E   <= MdStart_D;
      MemToReg_E  <= MemToReg_D;
      InstrType_E <= InstrType_D;
      TNew_E      <= TNew_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt <= 4'd0;
    end else if (MdStart_E) begin
      md_cnt <= MdLatCnt;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      StallCnt <= 32'd0;
    end else if (Stall && (StallCnt != 32'hFFFF_FFFF)) begin
      StallCnt <= StallCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stall_reg_d.sv
// Directed self-checking bench for stall_reg_d: reset, data hazards, $0 immunity, md busy.
module tb_stall_reg_d;

  localparam logic [7:0] NopType = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Pc_D, RD1_D, RD2_D;
  logic [4:0]  Addr1_D, Addr2_D, WR_D, WR_M;
  logic        RegWrite_D, MemWrite_D, MdStart_D, MdUse_D, RegWrite_M;
  logic [1:0]  MemToReg_D;
  logic [7:0]  InstrType_D, TNew_D, TUse1_D, TUse2_D, TNew_M;
  logic [31:0] Pc_E, RD1_E, RD2_E;
  logic [4:0]  Addr1_E, Addr2_E, WR_E;
  logic        RegWrite_E, MemWrite_E, MdStart_E;
  logic [1:0]  MemToReg_E;
  logic [7:0]  InstrType_E, TNew_E;
  logic        Stall, MdBusy;
`ifdef STALL_CNT_EN
  logic [31:0] StallCnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stall_reg_d #(.NOP_TYPE(NopType), .MD_LAT(5)) dut (
    .clk(clk), .reset(reset),
    .Pc_D(Pc_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
    .Addr1_D(Addr1_D), .Addr2_D(Addr2_D), .WR_D(WR_D),
    .RegWrite_D(RegWrite_D), .MemWrite_D(MemWrite_D), .MemToReg_D(MemToReg_D),
    .InstrType_D(InstrType_D), .TNew_D(TNew_D), .TUse1_D(TUse1_D), .TUse2_D(TUse2_D),
    .MdStart_D(MdStart_D), .MdUse_D(MdUse_D),
    .WR_M(WR_M), .RegWrite_M(RegWrite_M), .TNew_M(TNew_M),
    .Pc_E(Pc_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Addr1_E(Addr1_E), .Addr2_E(Addr2_E), .WR_E(WR_E),
    .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .MdStart_E(MdStart_E),
    .MemToReg_E(MemToReg_E), .InstrType_E(InstrType_E), .TNew_E(TNew_E),
`ifdef STALL_CNT_EN
    .StallCnt(StallCnt),
`endif
    .Stall(Stall), .MdBusy(MdBusy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Pc_D = 32'd0; RD1_D = 32'd0; RD2_D = 32'd0;
    Addr1_D = 5'd0; Addr2_D = 5'd0; WR_D = 5'd0;
    RegWrite_D = 1'b0; MemWrite_D = 1'b0; MemToReg_D = 2'd0;
    InstrType_D = 8'd0; TNew_D = 8'd0; TUse1_D = 8'd0; TUse2_D = 8'd0;
    MdStart_D = 1'b0; MdUse_D = 1'b0;
    WR_M = 5'd0; RegWrite_M = 1'b0; TNew_M = 8'd0;
    #1;
  endtask

  // Push an all-zero instruction through E so the next scenario starts hazard-free.
  task automatic flush();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    Pc_D = 32'h1234_5678; RD1_D = 32'hFFFF_0000; WR_D = 5'd3; RegWrite_D = 1'b1;
    InstrType_D = 8'h11; TNew_D = 8'd2; MdStart_D = 1'b1;
    reset = 1'b0;
    tick(); tick();
    n_checks++; if (Pc_E !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc got %h want 00003000", Pc_E); end
    n_checks++; if (InstrType_E !== NopType) begin n_fail++; $display("FAIL reset_type got %h want %h", InstrType_E, NopType); end
    n_checks++; if (RegWrite_E !== 1'b0 || WR_E !== 5'd0 || TNew_E !== 8'd0 || RD1_E !== 32'd0 || MdStart_E !== 1'b0) begin
      n_fail++; $display("FAIL reset_fields got rw=%b wr=%0d tnew=%0d rd1=%h md=%b want zeros", RegWrite_E, WR_E, TNew_E, RD1_E, MdStart_E);
    end
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", Stall); end
    n_checks++; if (MdBusy !== 1'b0) begin n_fail++; $display("FAIL reset_mdbusy got %b want 0", MdBusy); end
`ifdef STALL_CNT_EN
    n_checks++; if (StallCnt !== 32'd0) begin n_fail++; $display("FAIL reset_stallcnt got %0d want 0", StallCnt); end
`endif
    reset = 1'b1;
    flush();
  endtask

  task automatic test_load_use();
    clear_inputs();
    Pc_D = 32'h100; WR_D = 5'd8; RegWrite_D = 1'b1; TNew_D = 8'd2; InstrType_D = 8'h03;
    MemToReg_D = 2'd1; RD2_D = 32'h0000_0042; Addr2_D = 5'd4;
    tick();
    n_checks++; if (Pc_E !== 32'h100 || WR_E !== 5'd8 || RegWrite_E !== 1'b1 || TNew_E !== 8'd2 ||
                    InstrType_E !== 8'h03 || MemToReg_E !== 2'd1 || RD2_E !== 32'h42 || Addr2_E !== 5'd4) begin
      n_fail++; $display("FAIL passthrough got pc=%h wr=%0d rw=%b tnew=%0d type=%h mtr=%0d rd2=%h a2=%0d want 100/8/1/2/03/1/42/4",
                          Pc_E, WR_E, RegWrite_E, TNew_E, InstrType_E, MemToReg_E, RD2_E, Addr2_E);
    end
    clear_inputs();
    Pc_D = 32'h104; Addr1_D = 5'd8; TUse1_D = 8'd0; WR_D = 5'd10; RegWrite_D = 1'b1;
    TNew_D = 8'd1; RD1_D = 32'hDEAD_BEEF; InstrType_D = 8'h01; MemWrite_D = 1'b1;
    #1;
    n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL loaduse_stall1 got %b want 1", Stall); end
    tick();
    n_checks++; if (InstrType_E !== NopType || RegWrite_E !== 1'b0 || WR_E !== 5'd0 || RD1_E !== 32'd0 ||
                    Addr1_E !== 5'd0 || MemWrite_E !== 1'b0 || TNew_E !== 8'd0 || Pc_E !== 32'h104) begin
      n_fail++; $display("FAIL loaduse_bubble1 got type=%h rw=%b wr=%0d rd1=%h a1=%0d mw=%b tnew=%0d pc=%h want %h/0/0/0/0/0/0/104",
                          InstrType_E, RegWrite_E, WR_E, RD1_E, Addr1_E, MemWrite_E, TNew_E, Pc_E, NopType);
    end
    // Producer now in M, one cycle from its result.
    WR_M = 5'd8; RegWrite_M = 1'b1; TNew_M = 8'd1;
    #1;
    n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL loaduse_stall2 got %b want 1", Stall); end
    tick();
    n_checks++; if (InstrType_E !== NopType || RegWrite_E !== 1'b0) begin
      n_fail++; $display("FAIL loaduse_bubble2 got type=%h rw=%b want %h/0", InstrType_E, RegWrite_E, NopType);
    end
    TNew_M = 8'd0;
    #1;
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL loaduse_release got %b want 0", Stall); end
    tick();
    n_checks++; if (Pc_E !== 32'h104 || WR_E !== 5'd10 || RD1_E !== 32'hDEAD_BEEF || RegWrite_E !== 1'b1 ||
                    InstrType_E !== 8'h01 || Addr1_E !== 5'd8 || TNew_E !== 8'd1 || MemWrite_E !== 1'b1) begin
      n_fail++; $display("FAIL loaduse_pass got pc=%h wr=%0d rd1=%h rw=%b type=%h a1=%0d tnew=%0d mw=%b want 104/10/deadbeef/1/01/8/1/1",
                          Pc_E, WR_E, RD1_E, RegWrite_E, InstrType_E, Addr1_E, TNew_E, MemWrite_E);
    end
    flush();
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    Pc_D = 32'h200; WR_D = 5'd0; RegWrite_D = 1'b1; TNew_D = 8'd2;
    tick();
    clear_inputs();
    Pc_D = 32'h204; Addr1_D = 5'd0; TUse1_D = 8'd0; WR_D = 5'd5; RegWrite_D = 1'b1;
    #1;
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL zero_reg_stall got %b want 0", Stall); end
    tick();
    n_checks++; if (Pc_E !== 32'h204 || WR_E !== 5'd5) begin
      n_fail++; $display("FAIL zero_reg_pass got pc=%h wr=%0d want 204/5", Pc_E, WR_E);
    end
    flush();
  endtask

  task automatic test_m_hazard();
    clear_inputs();
    WR_M = 5'd9; RegWrite_M = 1'b1; TNew_M = 8'd1;
    Pc_D = 32'h300; Addr2_D = 5'd9; TUse2_D = 8'd0; WR_D = 5'd7; RegWrite_D = 1'b1;
    #1;
    n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL m_hazard_stall got %b want 1", Stall); end
    tick();
    n_checks++; if (InstrType_E !== NopType || WR_E !== 5'd0) begin
      n_fail++; $display("FAIL m_hazard_bubble got type=%h wr=%0d want %h/0", InstrType_E, WR_E, NopType);
    end
    TNew_M = 8'd0;
    #1;
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL m_hazard_release got %b want 0", Stall); end
    tick();
    n_checks++; if (Pc_E !== 32'h300 || WR_E !== 5'd7 || Addr2_E !== 5'd9) begin
      n_fail++; $display("FAIL m_hazard_pass got pc=%h wr=%0d a2=%0d want 300/7/9", Pc_E, WR_E, Addr2_E);
    end
    flush();
  endtask

  task automatic test_tuse_boundary();
    // TNew equal to TUse is not a hazard: the value forwards in time.
    clear_inputs();
    WR_D = 5'd12; RegWrite_D = 1'b1; TNew_D = 8'd1;
    tick();
    clear_inputs();
    Addr2_D = 5'd12; TUse2_D = 8'd1;
    #1;
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL tuse_equal got %b want 0", Stall); end
    // Matching in both E and M still stalls.
    TUse2_D = 8'd0; WR_M = 5'd12; RegWrite_M = 1'b1; TNew_M = 8'd1;
    #1;
    n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL e_and_m_match got %b want 1", Stall); end
    // rt match in E alone with a later-needed rs unaffected.
    WR_M = 5'd0; RegWrite_M = 1'b0; TNew_M = 8'd0;
    #1;
    n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL e2_match got %b want 1", Stall); end
    flush();
    flush();
  endtask

  task automatic test_md_busy();
`ifdef STALL_CNT_EN
    logic [31:0] cnt0;
`endif
    clear_inputs();
    Pc_D = 32'h400; MdStart_D = 1'b1;
    tick();
    n_checks++; if (MdStart_E !== 1'b1 || MdBusy !== 1'b0) begin
      n_fail++; $display("FAIL md_start_e got mdstart=%b busy=%b want 1/0", MdStart_E, MdBusy);
    end
`ifdef STALL_CNT_EN
    cnt0 = StallCnt;
`endif
    clear_inputs();
    Pc_D = 32'h404; MdUse_D = 1'b1; WR_D = 5'd2; RegWrite_D = 1'b1;
    #1;
    for (int k = 1; k <= 6; k++) begin
      n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL md_stall cycle %0d got %b want 1", k, Stall); end
      tick();
      n_checks++; if (MdBusy !== (k <= 5)) begin n_fail++; $display("FAIL md_busy after %0d got %b want %b", k, MdBusy, (k <= 5)); end
    end
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL md_release got %b want 0", Stall); end
    tick();
    n_checks++; if (Pc_E !== 32'h404 || WR_E !== 5'd2 || MdStart_E !== 1'b0) begin
      n_fail++; $display("FAIL md_pass got pc=%h wr=%0d mdstart=%b want 404/2/0", Pc_E, WR_E, MdStart_E);
    end
`ifdef STALL_CNT_EN
    n_checks++; if (StallCnt !== cnt0 + 32'd6) begin n_fail++; $display("FAIL md_stallcnt got %0d want %0d", StallCnt, cnt0 + 32'd6); end
`endif
    flush();
  endtask

  task automatic test_reset_mid_md();
    clear_inputs();
    MdStart_D = 1'b1;
    tick();
    flush(); flush(); flush();
    n_checks++; if (MdBusy !== 1'b1) begin n_fail++; $display("FAIL mid_md_busy got %b want 1", MdBusy); end
    MdUse_D = 1'b1;
    #1;
    n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL mid_md_stall got %b want 1", Stall); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_checks++; if (MdBusy !== 1'b0 || Stall !== 1'b0) begin
      n_fail++; $display("FAIL mid_md_reset got busy=%b stall=%b want 0/0", MdBusy, Stall);
    end
    n_checks++; if (Pc_E !== 32'h0000_3000 || InstrType_E !== NopType) begin
      n_fail++; $display("FAIL mid_md_reset_e got pc=%h type=%h want 00003000/%h", Pc_E, InstrType_E, NopType);
    end
`ifdef STALL_CNT_EN
    n_checks++; if (StallCnt !== 32'd0) begin n_fail++; $display("FAIL mid_md_stallcnt got %0d want 0", StallCnt); end
`endif
    flush();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_m_hazard();
    test_tuse_boundary();
    test_md_busy();
    test_reset_mid_md();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
